// File: rtl/if_id_hazard_stage.sv
// rtl/if_id_hazard_stage.sv - IF/ID pipeline register with read-after-write stall scoreboard
module if_id_hazard_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned HAZ_DEPTH = 3,
  parameter logic [31:0] NOP_INST  = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            fetch_valid,
  input  logic            br_taken,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic            rd_wren_id,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            id_valid,
  output logic            pc_stall,
  output logic            bubble_o,
  output logic [31:0]     stall_cnt
);

  logic [31:0]                r_inst;
  logic [XLEN-1:0]            r_pc;
  logic                       r_valid;
  logic [HAZ_DEPTH-1:0]       r_sb_v;
  logic [HAZ_DEPTH-1:0][4:0]  r_sb_rd;
  logic [31:0]                r_stall_cnt;

  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;
  logic       w_hit1;
  logic       w_hit2;
  logic       w_hazard;
  logic       w_stall;
  logic       w_issue;

  assign w_rs1 = r_inst[19:15];
  assign w_rs2 = r_inst[24:20];
  assign w_rd  = r_inst[11:7];

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int k = 0; k < HAZ_DEPTH; k++) begin
      if (r_sb_v[k] && (r_sb_rd[k] == w_rs1)) w_hit1 = 1'b1;
      if (r_sb_v[k] && (r_sb_rd[k] == w_rs2)) w_hit2 = 1'b1;
    end
  end

  // x0 is excluded here and again on entry, so it can never hold up a reader
  assign w_hazard = r_valid & ((rs1_used & (w_rs1 != 5'd0) & w_hit1) |
                               (rs2_used & (w_rs2 != 5'd0) & w_hit2));
  assign w_stall  = w_hazard & ~br_taken;
  assign w_issue  = r_valid & rd_wren_id & (w_rd != 5'd0) & ~w_hazard & ~br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_v  <= '0;
      r_sb_rd <= '0;
    end else begin
      for (int k = 1; k < HAZ_DEPTH; k++) begin
        r_sb_v[k]  <= r_sb_v[k-1];
        r_sb_rd[k] <= r_sb_rd[k-1];
      end
      r_sb_v[0]  <= w_issue;
      r_sb_rd[0] <= w_rd;
    end
  end

  // A branch flush outranks a pending stall: the held instruction is discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst  <= NOP_INST;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (br_taken) begin
      r_inst  <= NOP_INST;
      r_pc    <= pc_i;
      r_valid <= 1'b0;
    end else if (!w_stall) begin
      r_inst  <= fetch_valid ? inst_i : NOP_INST;
      r_pc    <= pc_i;
      r_valid <= fetch_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign inst_o    = r_inst;
  assign pc_o      = r_pc;
  assign id_valid  = r_valid;
  assign pc_stall  = w_stall;
  assign bubble_o  = w_hazard | br_taken | ~r_valid;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// tb/tb_if_id_hazard_stage.sv - directed table, corner sequences and randomized model check
module tb_if_id_hazard_stage;

  localparam int HD = 3;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ADDI1 = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD   = 32'h00108133; // add x2,x1,x1
  localparam logic [31:0] ADDI3 = 32'h00100193; // addi x3,x0,1
  localparam logic [31:0] ADDI4 = 32'h00400213; // addi x4,x0,4
  localparam logic [31:0] ADDX0 = 32'h00500013; // addi x0,x0,5
  localparam logic [31:0] ADDR0 = 32'h00000133; // add x2,x0,x0
  localparam logic [31:0] LUI5  = 32'h000282b7; // lui x5,0x28 (rs1 field = 5)
  localparam logic [31:0] NA    = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        fetch_valid, br_taken, rs1_used, rs2_used, rd_wren_id;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        id_valid, pc_stall, bubble_o;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_err    = 0;

  if_id_hazard_stage #(.XLEN(32), .HAZ_DEPTH(HD), .NOP_INST(32'h00000013)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .pc_i(pc_i), .fetch_valid(fetch_valid),
    .br_taken(br_taken), .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_wren_id(rd_wren_id),
    .inst_o(inst_o), .pc_o(pc_o), .id_valid(id_valid), .pc_stall(pc_stall),
    .bubble_o(bubble_o), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] inst;
    logic        fv;
    logic        br;
    logic [2:0]  dec;
    logic [31:0] pc;
    logic        chk;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_stall;
    logic        e_bubble;
    logic [31:0] e_cnt;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(logic r, logic [31:0] inst, logic fv, logic br, logic [2:0] dec,
                              logic [31:0] pc, logic chk, logic [31:0] e_inst, logic e_valid,
                              logic e_stall, logic e_bubble, logic [31:0] e_cnt, logic [31:0] e_pc);
    vec_t t;
    t.rst = r; t.inst = inst; t.fv = fv; t.br = br; t.dec = dec; t.pc = pc; t.chk = chk;
    t.e_inst = e_inst; t.e_valid = e_valid; t.e_stall = e_stall; t.e_bubble = e_bubble;
    t.e_cnt = e_cnt; t.e_pc = e_pc;
    tbl.push_back(t);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [31:0] inst, logic fv, logic br, logic [2:0] dec, logic [31:0] pc);
    rst = r; inst_i = inst; fetch_valid = fv; br_taken = br;
    rs1_used = dec[2]; rs2_used = dec[1]; rd_wren_id = dec[0]; pc_i = pc;
  endtask

  // Reference model: remembers, per register, the cycle its latest producer entered EX
  logic [31:0] m_inst, m_pc, m_cnt;
  logic        m_valid;
  int          last_wr[32];
  int          cur;

  function automatic logic busy(logic [4:0] r);
    return (r != 5'd0) && ((cur - last_wr[r]) < HD);
  endfunction

  task automatic model_reset();
    m_inst = NOP; m_pc = '0; m_valid = 1'b0; m_cnt = '0;
    for (int r = 0; r < 32; r++) last_wr[r] = -1000;
  endtask

  initial begin
    drive(1'b1, NOP, 1'b0, 1'b0, 3'b000, 32'd0);
    cur = 0;

    row(1, NOP,   0, 0, 3'b000, 0,      0, NOP,   0, 0, 1, 0, NA);
    row(1, NOP,   0, 0, 3'b000, 0,      0, NOP,   0, 0, 1, 0, NA);
    row(0, ADDI1, 1, 0, 3'b000, 0,      1, NOP,   0, 0, 1, 0, 0);
    row(0, ADD,   1, 0, 3'b101, 0,      1, ADDI1, 1, 0, 0, 0, NA);
    row(0, NOP,   0, 0, 3'b111, 0,      1, ADD,   1, 1, 1, 0, NA);
    row(0, NOP,   0, 0, 3'b111, 0,      1, ADD,   1, 1, 1, 1, NA);
    row(0, NOP,   0, 0, 3'b111, 0,      1, ADD,   1, 1, 1, 2, NA);
    row(0, NOP,   0, 0, 3'b111, 0,      1, ADD,   1, 0, 0, 3, NA);
    row(0, ADDI1, 1, 0, 3'b000, 0,      1, NOP,   0, 0, 1, 3, NA);
    row(0, ADDI3, 1, 0, 3'b101, 0,      1, ADDI1, 1, 0, 0, 3, NA);
    row(0, ADD,   1, 0, 3'b101, 0,      1, ADDI3, 1, 0, 0, 3, NA);
    row(0, NOP,   0, 0, 3'b111, 0,      1, ADD,   1, 1, 1, 3, NA);
    row(0, NOP,   0, 0, 3'b111, 0,      1, ADD,   1, 1, 1, 4, NA);
    row(0, ADDI1, 1, 0, 3'b111, 0,      1, ADD,   1, 0, 0, 5, NA);
    row(0, ADDI3, 1, 0, 3'b101, 0,      1, ADDI1, 1, 0, 0, 5, NA);
    row(0, ADDI3, 1, 0, 3'b101, 0,      1, ADDI3, 1, 0, 0, 5, NA);
    row(0, ADDI3, 1, 0, 3'b101, 0,      1, ADDI3, 1, 0, 0, 5, NA);
    row(0, ADD,   1, 0, 3'b101, 0,      1, ADDI3, 1, 0, 0, 5, NA);
    row(0, NOP,   0, 0, 3'b111, 0,      1, ADD,   1, 0, 0, 5, NA);
    row(0, ADDX0, 1, 0, 3'b000, 0,      1, NOP,   0, 0, 1, 5, NA);
    row(0, ADDR0, 1, 0, 3'b101, 0,      1, ADDX0, 1, 0, 0, 5, NA);
    row(0, LUI5,  1, 0, 3'b111, 0,      1, ADDR0, 1, 0, 0, 5, NA);
    row(0, LUI5,  1, 0, 3'b001, 0,      1, LUI5,  1, 0, 0, 5, NA);
    row(0, NOP,   0, 0, 3'b001, 0,      1, LUI5,  1, 0, 0, 5, NA);
    row(0, ADDI1, 1, 0, 3'b000, 32'h100, 1, NOP,  0, 0, 1, 5, NA);
    row(0, ADD,   1, 0, 3'b101, 32'h104, 1, ADDI1, 1, 0, 0, 5, 32'h100);
    row(0, ADDI4, 1, 0, 3'b111, 32'h108, 1, ADD,  1, 1, 1, 5, 32'h104);
    row(0, ADDI4, 1, 1, 3'b111, 32'h200, 1, ADD,  1, 0, 1, 6, 32'h104);
    row(0, NOP,   0, 0, 3'b000, 32'h0,   1, NOP,  0, 0, 1, 6, 32'h200);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].inst, tbl[i].fv, tbl[i].br, tbl[i].dec, tbl[i].pc);
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("row%0d inst_o", i),   inst_o,          tbl[i].e_inst);
        chk($sformatf("row%0d id_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].e_valid});
        chk($sformatf("row%0d pc_stall", i), {31'd0, pc_stall}, {31'd0, tbl[i].e_stall});
        chk($sformatf("row%0d bubble_o", i), {31'd0, bubble_o}, {31'd0, tbl[i].e_bubble});
        chk($sformatf("row%0d stall_cnt", i), stall_cnt,      tbl[i].e_cnt);
        if (tbl[i].e_pc != NA) chk($sformatf("row%0d pc_o", i), pc_o, tbl[i].e_pc);
      end
    end

    // Reset asserted in the middle of a stall clears the scoreboard
    @(negedge clk); drive(0, ADDI1, 1, 0, 3'b000, 0);
    @(negedge clk); drive(0, ADD,   1, 0, 3'b101, 0);
    @(negedge clk); drive(1, NOP,   0, 0, 3'b111, 0); #1;
    chk("midrst stall_before", {31'd0, pc_stall}, 32'd1);
    @(negedge clk); drive(0, ADD,   1, 0, 3'b000, 0); #1;
    chk("midrst valid", {31'd0, id_valid}, 32'd0);
    chk("midrst stall", {31'd0, pc_stall}, 32'd0);
    chk("midrst cnt", stall_cnt, 32'd0);
    @(negedge clk); drive(0, NOP,   0, 0, 3'b111, 0); #1;
    chk("midrst inst", inst_o, ADD);
    chk("midrst sb_cleared", {31'd0, pc_stall}, 32'd0);

    // Counter saturation
    @(negedge clk); drive(0, ADDI1, 1, 0, 3'b000, 0);
    @(negedge clk); drive(0, ADD,   1, 0, 3'b101, 0);
    @(negedge clk); drive(0, NOP,   0, 0, 3'b111, 0);
    dut.r_stall_cnt = 32'hFFFFFFFE;
    #1 chk("sat stall", {31'd0, pc_stall}, 32'd1);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); #1;
      chk($sformatf("sat cnt%0d", s), stall_cnt, 32'hFFFFFFFF);
    end
    chk("sat released", {31'd0, pc_stall}, 32'd0);

    // Randomized run against the reference model
    @(negedge clk); drive(1, NOP, 0, 0, 3'b000, 0);
    @(negedge clk);
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic        r, fv, br, hz, st;
      logic [2:0]  dec;
      logic [31:0] inst, pc;
      logic [4:0]  rs1, rs2, rd;
      @(negedge clk);
      r    = ($urandom_range(0, 63) == 0);
      inst = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom), 5'($urandom_range(0, 3)), 7'($urandom)};
      fv   = ($urandom_range(0, 3) != 0);
      br   = ($urandom_range(0, 7) == 0);
      dec  = 3'($urandom);
      pc   = $urandom;
      drive(r, inst, fv, br, dec, pc);
      #1;
      rs1 = m_inst[19:15]; rs2 = m_inst[24:20]; rd = m_inst[11:7];
      hz  = m_valid && ((dec[2] && busy(rs1)) || (dec[1] && busy(rs2)));
      st  = hz && !br;
      chk($sformatf("rnd%0d inst_o", c), inst_o, m_inst);
      chk($sformatf("rnd%0d pc_o", c), pc_o, m_pc);
      chk($sformatf("rnd%0d id_valid", c), {31'd0, id_valid}, {31'd0, m_valid});
      chk($sformatf("rnd%0d pc_stall", c), {31'd0, pc_stall}, {31'd0, st});
      chk($sformatf("rnd%0d bubble_o", c), {31'd0, bubble_o}, {31'd0, hz || br || !m_valid});
      chk($sformatf("rnd%0d stall_cnt", c), stall_cnt, m_cnt);
      cur++;
      if (r) begin
        model_reset();
      end else begin
        if (st && m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
        if (m_valid && dec[0] && rd != 5'd0 && !hz && !br) last_wr[rd] = cur;
        if (br) begin
          m_inst = NOP; m_pc = pc; m_valid = 1'b0;
        end else if (!st) begin
          m_inst = fv ? inst : NOP; m_pc = pc; m_valid = fv;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_stage.md
# if_id_hazard_stage

IF/ID pipeline register with an integrated load-use/RAW stall controller for the stalling (no-forwarding) RV32I pipeline. It latches the fetched instruction and PC and tracks destination registers of instructions still in flight in EX/MEM/WB. On a read-after-write conflict it freezes PC and IF/ID and injects a bubble into the ID/EX register. A taken branch from EX flushes the fetched instruction.

## Interface
Parameters:
- XLEN, 32, data/PC width
- HAZ_DEPTH, 3, number of downstream stages whose pending register write blocks a read (legal 1..4)
- NOP_INST, 32'h00000013, encoding loaded on flush/reset (addi x0,x0,0)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- inst_i  in  32  instruction from fetch
- pc_i  in  XLEN  PC of inst_i
- fetch_valid  in  1  inst_i is valid this cycle
- br_taken  in  1  taken branch/jump resolved in EX this cycle
- rs1_used  in  1  decoder: inst_o reads rs1 (combinational from inst_o)
- rs2_used  in  1  decoder: inst_o reads rs2
- rd_wren_id  in  1  decoder: inst_o writes rd
- inst_o  out  32  registered instruction to decode
- pc_o  out  XLEN  registered PC to decode
- id_valid  out  1  inst_o is a live instruction
- pc_stall  out  1  hold PC register this cycle
- bubble_o  out  1  ID/EX must capture a NOP (rd_wren=0, mem_wren=0)
- stall_cnt  out  32  saturating count of hazard-stall cycles

## Operation
- rs1 = inst_o[19:15], rs2 = inst_o[24:20], rd = inst_o[11:7].
- Scoreboard: HAZ_DEPTH entries {v, rd}; entry 0 = instruction now in EX, entry k = k stages further.
- hazard (combinational) = id_valid & ((rs1_used & rs1!=0 & any valid entry with rd==rs1) | (rs2_used & rs2!=0 & any valid entry with rd==rs2)).
- stall = hazard & ~br_taken. pc_stall = stall. bubble_o = hazard | br_taken | ~id_valid.
- Scoreboard each cycle: entries shift k→k+1, oldest discarded; entry 0 loads v = id_valid & rd_wren_id & rd!=0 & ~hazard & ~br_taken, rd = rd.
- IF/ID update priority:
  1. rst: inst_o=NOP_INST, pc_o=0, id_valid=0.
  2. br_taken: inst_o=NOP_INST, id_valid=0, pc_o=pc_i (flush dominates stall).
  3. stall: hold inst_o, pc_o, id_valid.
  4. else: inst_o = fetch_valid ? inst_i : NOP_INST; pc_o=pc_i; id_valid=fetch_valid.
- stall_cnt increments by 1 on every cycle with stall=1; saturates at 32'hFFFFFFFF; never wraps.
- x0 never creates or matches a hazard.

## Timing
- Reset values: inst_o=32'h00000013, pc_o=0, id_valid=0, all scoreboard v=0, stall_cnt=0; hence bubble_o=1, pc_stall=0 out of reset.
- IF/ID latency: 1 cycle from inst_i to inst_o.
- pc_stall, bubble_o are combinational from registered state plus br_taken/decoder inputs; valid in the same cycle.
- Dependency at distance d (1 ≤ d ≤ HAZ_DEPTH) stalls HAZ_DEPTH−d+1 cycles; d > HAZ_DEPTH: no stall.
- Stall released on the cycle the producing entry shifts out; consumer issues that edge.
- br_taken during stall: stall drops the same cycle, ID instruction discarded (bubble), no scoreboard entry.
- rst asserted mid-stall: all state cleared next edge; no stall on the following cycle.
- Simultaneous rs1 and rs2 hazards on different entries: stall until the youngest clears.

## Test plan
- Reset: hold rst 2 cycles -> inst_o=0x00000013, id_valid=0, bubble_o=1, pc_stall=0, stall_cnt=0.
- Back-to-back RAW: addi x1,x0,5 then add x2,x1,x1 -> pc_stall=1 for exactly 3 cycles, 3 bubbles, add issues 4th cycle, stall_cnt=3.
- Distance 2 and 4: one independent instruction between producer and consumer -> 2 stall cycles; three independent instructions -> 0 stalls.
- x0 and unused operand: producer writes x0, consumer reads x0; lui x5 followed by lui x5 (rs unused) -> no stall.
- Flush during stall: br_taken asserted in 2nd stall cycle -> pc_stall=0 same cycle, next inst_o=NOP, id_valid=0, stall_cnt=1.
- Counter saturation: force stall_cnt to 32'hFFFFFFFE, run 3 stall cycles -> stall_cnt=32'hFFFFFFFF, held.
